// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the LSTM activation datapath.
// Activations are signed Q4.4. LUT entries pair a segment base with the
// value at the following segment.
package nn_fixed_pkg;

    localparam int NN_DATA_W = 8;
    localparam int NN_ADDR_W = 4;
    localparam int NN_FRAC_W = NN_DATA_W - NN_ADDR_W;

    // sigmoid(x) scaled by 16, so 1.0 in the output domain
    localparam int SIG_ONE = 16;

    typedef logic signed [NN_DATA_W-1:0] q4_4_t;

    typedef struct packed {
        q4_4_t base;
        q4_4_t next;
    } lut_entry_t;

endpackage

// File: rtl/sigmoid_act.sv
// Integration wrapper pairing the interpolator with the sigmoid table.
// The table lives here rather than inside the interpolator so the same
// interpolator can be reused with a tanh table.
module sigmoid_act
    import nn_fixed_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NN_DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NN_DATA_W-1:0] out_data
);

    logic [NN_ADDR_W-1:0] lut_address_s;
    logic [NN_DATA_W-1:0] lut_base_s;
    logic [NN_DATA_W-1:0] lut_next_s;

    sigmoid_lut u_lut (
        .lut_address (lut_address_s),
        .lut_base    (lut_base_s),
        .lut_next    (lut_next_s)
    );

    sigmoid_interp u_interp (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lut_address (lut_address_s),
        .lut_base    (lut_base_s),
        .lut_next    (lut_next_s),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

endmodule

// File: rtl/sigmoid_lut.sv
// Combinational 16-entry sigmoid table, floor(16*sigmoid(n)) for integer n.
// Indices 0..7 hold n = 0..7 and indices 8..15 hold n = -8..-1.
// The next-segment value saturates at index 7 and wraps from 15 (n=-1)
// to 0 (n=0), so the interpolator never needs to know the table layout.
module sigmoid_lut
    import nn_fixed_pkg::*;
(
    input  logic [NN_ADDR_W-1:0] lut_address,
    output logic [NN_DATA_W-1:0] lut_base,
    output logic [NN_DATA_W-1:0] lut_next
);

    function automatic q4_4_t sig_value(input logic [NN_ADDR_W-1:0] idx);
        case (idx)
            4'd0:    sig_value = q4_4_t'(SIG_ONE / 2);
            4'd1:    sig_value = 8'sd11;
            4'd2:    sig_value = 8'sd14;
            4'd3:    sig_value = 8'sd15;
            4'd4:    sig_value = 8'sd15;
            4'd5:    sig_value = 8'sd15;
            4'd6:    sig_value = 8'sd15;
            4'd7:    sig_value = 8'sd15;
            4'd14:   sig_value = 8'sd1;
            4'd15:   sig_value = 8'sd4;
            default: sig_value = 8'sd0;
        endcase
    endfunction

    logic [NN_ADDR_W-1:0] next_idx_s;
    lut_entry_t           entry_s;

    // Select the neighbouring segment and look up both table values
    always_comb begin
        next_idx_s = 4'd0;
        if (lut_address == 4'd7) begin
            next_idx_s = lut_address;
        end else begin
            next_idx_s = lut_address + 4'd1;
        end
        entry_s.base = sig_value(lut_address);
        entry_s.next = sig_value(next_idx_s);
    end

    assign lut_base = entry_s.base;
    assign lut_next = entry_s.next;

endmodule

// File: rtl/sigmoid_interp.sv
// Three-stage piecewise-linear interpolator. S0 captures the sample and
// addresses the external LUT, S1 captures base/slope/fraction, and S2
// forms base + (slope*frac >>> FRAC_W). A single stall enable freezes all
// stages whenever the output is held by the consumer.
module sigmoid_interp
    import nn_fixed_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int ADDR_W = NN_ADDR_W,
    parameter int FRAC_W = DATA_W - ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] lut_address,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + FRAC_W + 1;

    logic                     en_s;
    logic                     accept_s;

    logic [DATA_W-1:0]        x0_r;
    logic                     v0_r;

    logic signed [DIFF_W-1:0] diff_next_s;
    logic signed [DATA_W-1:0] base1_r;
    logic signed [DIFF_W-1:0] diff1_r;
    logic [FRAC_W-1:0]        frac1_r;
    logic                     v1_r;

    logic signed [PROD_W-1:0] diff_ext_s;
    logic signed [PROD_W-1:0] frac_ext_s;
    logic signed [PROD_W-1:0] base_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic [DATA_W-1:0]        out_next_s;

    logic                     out_valid_r;
    logic [DATA_W-1:0]        out_data_r;

    // Global stall enable and input handshake; no acceptance while in reset
    always_comb begin
        en_s     = 1'b0;
        in_ready = 1'b0;
        accept_s = 1'b0;
        en_s     = !out_valid_r || out_ready;
        if (rst) begin
            in_ready = en_s;
        end else begin
            in_ready = 1'b0;
        end
        accept_s = in_valid && in_ready;
    end

    // S0: capture the raw sample; its integer part addresses the LUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x0_r <= '0;
            v0_r <= 1'b0;
        end else if (en_s) begin
            x0_r <= in_data;
            v0_r <= accept_s;
        end
    end

    assign lut_address = x0_r[DATA_W-1:FRAC_W];

    // Segment slope, widened by one bit so the subtraction cannot wrap
    always_comb begin
        diff_next_s = '0;
        diff_next_s = DIFF_W'($signed(lut_next)) - DIFF_W'($signed(lut_base));
    end

    // S1: capture segment base, slope and the unsigned fraction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base1_r <= '0;
            diff1_r <= '0;
            frac1_r <= '0;
            v1_r    <= 1'b0;
        end else if (en_s) begin
            base1_r <= $signed(lut_base);
            diff1_r <= diff_next_s;
            frac1_r <= x0_r[FRAC_W-1:0];
            v1_r    <= v0_r;
        end
    end

    // S2 arithmetic: signed slope times zero-extended fraction, floor shift
    always_comb begin
        diff_ext_s = '0;
        frac_ext_s = '0;
        base_ext_s = '0;
        prod_s     = '0;
        out_next_s = '0;
        diff_ext_s = PROD_W'(diff1_r);
        frac_ext_s = PROD_W'({1'b0, frac1_r});
        base_ext_s = PROD_W'(base1_r);
        prod_s     = diff_ext_s * frac_ext_s;
        out_next_s = DATA_W'(base_ext_s + (prod_s >>> FRAC_W));
    end

    // S2: registered result, held while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (en_s) begin
            out_data_r  <= out_next_s;
            out_valid_r <= v1_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_sigmoid_interp.sv
// Directed bench for sigmoid_interp driven by the sigmoid table. Expected
// values come from a real-arithmetic sigmoid model; a negedge monitor keeps
// a scoreboard with acceptance time and stall count for latency checks.
module tb_sigmoid_interp;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] lut_address;
    logic [7:0] lut_base;
    logic [7:0] lut_next;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stalls   = 0;

    typedef struct {
        int exp;
        int acc;
        int stl;
    } ent_t;

    ent_t       q[$];
    int         recv[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clk = ~clk;

    sigmoid_lut u_lut (
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next)
    );

    sigmoid_interp dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    // floor(16 * sigmoid(n)) at an integer knot
    function automatic int seg_val(input int n);
        real s;
        s = 16.0 / (1.0 + $exp(-1.0 * n));
        return int'($floor(s));
    endfunction

    // Piecewise-linear sigmoid*16 of a Q4.4 value, knots saturate above 7
    function automatic int model(input logic [7:0] x);
        int  xi, seg, frac, b, nx;
        real r;
        xi   = int'($signed(x));
        seg  = (xi >= 0) ? xi / 16 : -((-xi + 15) / 16);
        frac = xi - 16 * seg;
        b    = seg_val(seg);
        nx   = (seg == 7) ? b : seg_val(seg + 1);
        r    = $floor(real'((nx - b) * frac) / 16.0);
        return b + int'(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_data", int'(out_data), int'(prev_data));
                check("stall_hold_valid", int'(out_valid), 1);
            end
            if (out_valid && !out_ready)
                check("stall_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                check("output_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("out_data", int'($signed(out_data)), e.exp);
                    check("latency", cyc, e.acc + 2 + (stalls - e.stl));
                    recv.push_back(int'($signed(out_data)));
                end
            end
            if (in_valid && in_ready) begin
                e.exp = model(in_data);
                e.acc = cyc + 1;
                e.stl = stalls;
                q.push_back(e);
            end
            if (out_valid && !out_ready) stalls++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send(input logic [7:0] x);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_accept", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk);
        #3;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   exp_dir[8];
        logic [7:0] dir_x[8];
        logic [7:0] bp_x[6];

        exp_dir = '{8, 12, 15, 0, 6, 2, 7, 10};
        dir_x   = '{8'h00, 8'h18, 8'h7F, 8'h80, 8'hF8, 8'hE8, 8'hFF, 8'h0F};
        bp_x    = '{8'h10, 8'h20, 8'h30, 8'hF0, 8'hE0, 8'h08};

        // Model pins
        check("model_pin_00", model(8'h00), 8);
        check("model_pin_18", model(8'h18), 12);
        check("model_pin_ff", model(8'hFF), 7);
        check("model_pin_e8", model(8'hE8), 2);

        // Reset state with a valid request pending
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h18;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);

        // Directed values back-to-back, including the segment wrap cases
        @(posedge clk);
        #1;
        recv.delete();
        for (int i = 0; i < 8; i++) send(dir_x[i]);
        drain();
        check("directed_count", recv.size(), 8);
        for (int i = 0; i < 8; i++)
            check("directed_value", (i < recv.size()) ? recv[i] : -1, exp_dir[i]);

        // Backpressure mid-stream for four cycles
        @(posedge clk);
        #1;
        recv.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp_x[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", recv.size(), 6);
        for (int i = 0; i < 6; i++)
            check("bp_value", (i < recv.size()) ? recv[i] : -1, model(bp_x[i]));
        check("bp_stalls_seen", int'(stalls >= 4), 1);

        // Bubbles: one idle cycle after every sample
        @(posedge clk);
        #1;
        recv.delete();
        for (int i = 0; i < 4; i++) begin
            send(dir_x[i + 4]);
            @(posedge clk);
            #1;
        end
        drain();
        check("bubble_count", recv.size(), 4);

        // Reset with samples in flight
        @(posedge clk);
        #1;
        send(8'h18);
        send(8'h7F);
        send(8'h80);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        recv.delete();
        repeat (4) @(negedge clk);
        check("midrst_no_stale", int'(out_valid), 0);
        @(posedge clk);
        #1;
        send(8'h00);
        drain();
        check("midrst_new_count", recv.size(), 1);
        check("midrst_new_value", (recv.size() > 0) ? recv[0] : -1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sigmoid_interp.md
# sigmoid_interp

Pipelined piecewise-linear sigmoid evaluator for the LSTM output/gate path. Accepts one signed fixed-point pre-activation per cycle over a valid/ready handshake. Drives the 16-entry sigmoid LUT with the integer part of the sample and consumes the LUT's `base`/`next_data` pair. Interpolates on the fractional part and emits the activation to the downstream multiplier stage.

## Interface
- `DATA_W`, default 8: input/output width, signed two's complement.
- `ADDR_W`, default 4: LUT index width, taken from the top bits of the input.
- `FRAC_W`, default 4: fraction width, `DATA_W - ADDR_W`; input format Q4.4, output Q4.4 (sigmoid×16).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: block can accept a sample this cycle.
- `in_data` in DATA_W: pre-activation x, signed Q4.4.
- `lut_address` out ADDR_W: LUT index, driven from the stage-0 register.
- `lut_base` in DATA_W: LUT value at `lut_address`.
- `lut_next` in DATA_W: LUT value at the next segment. The LUT already handles index 7→7 saturation and 15→0 wrap.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out DATA_W: sigmoid(x)×16, signed.

## Operation
- Transfer occurs on an edge where `valid && ready`.
- Global stall enable `en = !out_valid || out_ready`. `in_ready = en` while `rst` is high, and 0 while `rst` is low. All pipeline registers load only when `en` is 1. Bubbles are not collapsed.
- Stage 0 (S0) registers `in_data` into `x0`, and `in_valid && in_ready` into `v0`.
- `lut_address = x0[DATA_W-1:FRAC_W]`, unsigned index. Negative x maps to indices 8..15, matching the LUT layout.
- Stage 1 (S1) registers:
  - `base1 = lut_base`
  - `diff1 = lut_next - lut_base`, computed sign-extended to DATA_W+1 bits
  - `frac1 = x0[FRAC_W-1:0]`, unsigned
  - `v1 = v0`
- Stage 2 (S2) computes `prod = diff1 * {0,frac1}`, signed, DATA_W+FRAC_W+1 bits.
- S2 registers `out_data = base1 + (prod >>> FRAC_W)`:
  - The shift is arithmetic, truncating toward −∞.
  - The result is truncated to DATA_W.
  - No saturation logic; the LUT range 0..15 guarantees the result fits.
- S2 also registers `out_valid = v1`.
- `out_data` holds its value while `out_valid && !out_ready`.
- No FSM. The control state is the valid bits `v0`, `v1`, `out_valid`.

## Timing
- Reset (async assert) clears `v0`, `v1`, `out_valid`, `x0`, `base1`, `diff1`, `frac1` and `out_data` to 0. `in_ready` reads 0 during reset and 1 from the first cycle after deassertion.
- Latency: a sample accepted at edge k appears on `out_data` with `out_valid=1` immediately after edge k+2.
- Throughput: 1 sample/cycle while `out_ready=1`.
- Backpressure: if `out_valid && !out_ready`, all stages freeze in the same cycle and `in_ready` drops combinationally. There is no loss or duplication, and acceptance resumes in the cycle `out_ready` returns high.
- Simultaneous `out_ready` rise and `in_valid` rise: both transfers happen on the same edge.
- Reset mid-operation: all in-flight samples are discarded, and no partial result is presented afterwards.
- LUT path: `lut_address` to `lut_base`/`lut_next` is combinational within one cycle and lies between the S0 and S1 registers.

## Structure
- Shared package `nn_fixed_pkg`:
  - `DATA_W`, `ADDR_W` and `FRAC_W` defaults
  - the Q4.4 fixed-point type
  - the LUT-entry type
  - constant `SIG_ONE = 16`
- Sub-module: `sigmoid_lut`, the existing combinational table. It is instantiated in the integration wrapper, not inside `sigmoid_interp`, so the tanh LUT can reuse this interpolator.
- Target size: about 150 lines of RTL.

## Test plan
- Reset check:
  - Hold `rst=0` and drive `in_valid=1` → `in_ready=0`, `out_valid=0`, `out_data=0`.
  - Release `rst` → `in_ready=1`.
- Directed values, streamed back-to-back with `out_ready=1`. Outputs appear in order, 2 cycles after each acceptance, one per cycle:
  - x=0x00 → 8
  - x=0x18 (1.5) → 12
  - x=0x7F → 15
  - x=0x80 (−8) → 0
  - x=0xF8 (−0.5) → 6
  - x=0xE8 (−1.5) → 2
- Segment wrap: x=0xFF → base 4, next 8, frac 15 → 7. Then x=0x0F → 10 (8 + (3·15)>>4).
- Backpressure: stream 6 samples and hold `out_ready=0` for 4 cycles starting mid-stream.
  - `out_data` must stay stable while stalled.
  - `in_ready` must be 0 while stalled.
  - All 6 results must arrive exactly once, in order.
- Bubble handling: alternate `in_valid` 1/0 → `out_valid` shows the same 1/0 pattern delayed by 2 cycles.
- Reset mid-stream: assert `rst` with 2 samples in flight → `out_valid` is 0 immediately (async). After release, no stale output appears, and a new x=0x00 yields 8 after 2 cycles.
